rbz_debug_probe: RTL and testbench

//  Parametrised debug-observation block for the raybox-zero top wrapper.
//  - Selects one of N_SIG probe signals, or a free-running clock-divider tap, onto a single debug pin.
//  - Synchronises and debounces the LA-driven select bus.
//  - Counts rising edges of the selected signal over a fixed gate window, so firmware can measure

---
 rtl/rbz_debug_probe.sv | 148 ++++++++++++++
 tb/tb_rbz_debug_probe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rbz_debug_probe.sv
// Debug observation block: routes one probe or divider tap to a pin and counts its
// rising edges over a fixed gate window so firmware can read frequencies over LA.
module rbz_debug_probe #(
    parameter int N_SIG       = 64,
    parameter int SEL_W       = 7,
    parameter int DIV_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ena,
    input  logic [N_SIG-1:0] i_probe,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_debug,
    output logic [SEL_W-1:0] o_sel_active,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_overflow
);
    localparam int N_MAP = 1 << SEL_W;
    localparam int WIN_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_reg;
    logic [SEL_W-1:0] sel_prev_reg;
    logic [SEL_W-1:0] sel_active_reg;
    logic [DIV_W-1:0] div_reg;
    logic             debug_reg;
    logic             prev_reg;
    logic [1:0]       mask_reg;
    logic [WIN_W-1:0] win_reg;
    logic [CNT_W-1:0] acc_reg;
    logic             acc_ovf_reg;
    logic [CNT_W-1:0] count_reg;
    logic             count_valid_reg;
    logic             overflow_reg;

    logic [SEL_W-1:0] sel_s;
    logic             sel_change;
    logic [N_MAP-1:0] map_vec;
    logic             mux_bit;
    logic             rise;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] acc_next;
    logic             ovf_next;
    logic             win_end;

    assign sel_s = sync_reg[SYNC_STAGES-1];
    // Two equal consecutive samples reject a select caught mid-transition.
    assign sel_change = (sel_s == sel_prev_reg) && (sel_s != sel_active_reg);

    genvar gi;
    generate
        for (gi = 0; gi < N_MAP; gi++) begin : g_map
            if (gi < N_SIG) begin : g_probe
                assign map_vec[gi] = i_probe[gi];
            end else if (gi < N_SIG + DIV_W) begin : g_div
                assign map_vec[gi] = div_reg[gi - N_SIG];
            end else begin : g_zero
                assign map_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign mux_bit  = map_vec[sel_active_reg];
    // Edges are suppressed while the pin still reflects the previous selection.
    assign rise     = debug_reg & ~prev_reg & (mask_reg == 2'd0);
    assign sum      = {1'b0, acc_reg} + (CNT_W + 1)'(rise);
    assign acc_next = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    assign ovf_next = acc_ovf_reg | sum[CNT_W];
    assign win_end  = (win_reg == WIN_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg        <= '0;
            sel_prev_reg    <= '0;
            sel_active_reg  <= '0;
            div_reg         <= '0;
            debug_reg       <= 1'b0;
            prev_reg        <= 1'b0;
            mask_reg        <= 2'd0;
            win_reg         <= '0;
            acc_reg         <= '0;
            acc_ovf_reg     <= 1'b0;
            count_reg       <= '0;
            count_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (!ena) begin
            sync_reg        <= '0;
            sel_prev_reg    <= '0;
            sel_active_reg  <= '0;
            div_reg         <= '0;
            debug_reg       <= 1'b0;
            prev_reg        <= 1'b0;
            mask_reg        <= 2'd0;
            win_reg         <= '0;
            acc_reg         <= '0;
            acc_ovf_reg     <= 1'b0;
            count_reg       <= '0;
            count_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            sync_reg[0] <= i_sel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sel_prev_reg    <= sel_s;
            div_reg         <= div_reg + DIV_W'(1);
            debug_reg       <= mux_bit;
            prev_reg        <= debug_reg;
            count_valid_reg <= 1'b0;

            if (sel_change) begin
                mask_reg <= 2'd2;
            end else if (mask_reg != 2'd0) begin
                mask_reg <= mask_reg - 2'd1;
            end

            // A select change discards the window even when it coincides with window end.
            if (sel_change) begin
                sel_active_reg <= sel_s;
                win_reg        <= '0;
                acc_reg        <= '0;
                acc_ovf_reg    <= 1'b0;
            end else if (win_end) begin
                count_reg       <= acc_next;
                overflow_reg    <= ovf_next;
                count_valid_reg <= 1'b1;
                win_reg         <= '0;
                acc_reg         <= '0;
                acc_ovf_reg     <= 1'b0;
            end else begin
                win_reg     <= win_reg + WIN_W'(1);
                acc_reg     <= acc_next;
                acc_ovf_reg <= ovf_next;
            end
        end
    end

    assign o_debug       = debug_reg;
    assign o_sel_active  = sel_active_reg;
    assign o_count       = count_reg;
    assign o_count_valid = count_valid_reg;
    assign o_overflow    = overflow_reg;
endmodule

// File: tb/tb_rbz_debug_probe.sv
// Directed bench for rbz_debug_probe: a 4-bit counter instance and a 2-bit one share stimulus.
module tb_rbz_debug_probe;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ena = 1'b1;
    logic [63:0] i_probe = '0;
    logic [6:0]  i_sel = '0;

    logic        debug_a, valid_a, ovf_a;
    logic [6:0]  sel_a;
    logic [3:0]  count_a;
    logic        debug_b, valid_b, ovf_b;
    logic [6:0]  sel_b;
    logic [1:0]  count_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e_at, p_at, p_prev;

    rbz_debug_probe #(.N_SIG(64), .SEL_W(7), .DIV_W(4), .SYNC_STAGES(2),
                      .CNT_W(4), .GATE_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .i_probe(i_probe), .i_sel(i_sel),
        .o_debug(debug_a), .o_sel_active(sel_a), .o_count(count_a),
        .o_count_valid(valid_a), .o_overflow(ovf_a)
    );

    rbz_debug_probe #(.N_SIG(64), .SEL_W(7), .DIV_W(4), .SYNC_STAGES(2),
                      .CNT_W(2), .GATE_CYCLES(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .i_probe(i_probe), .i_sel(i_sel),
        .o_debug(debug_b), .o_sel_active(sel_b), .o_count(count_b),
        .o_count_valid(valid_b), .o_overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_a === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_sel(input logic [6:0] v, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sel_a === v) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        // 1: reset with random inputs, then select probe 5
        i_probe = {$urandom, $urandom};
        i_sel   = 7'($urandom_range(0, 127));
        ticks(2);
        chk("rst_debug", debug_a, 0);
        chk("rst_sel", sel_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_ovf", ovf_a, 0);
        i_probe = 64'h20;
        i_sel   = 7'd5;
        reset_n = 1'b1;
        ticks(3);
        chk("sel_lat3", sel_a, 0);
        tick();
        chk("sel_lat4", sel_a, 5);
        chk("debug_lat0", debug_a, 0);
        tick();
        chk("debug_lat1", debug_a, 1);

        // 2: divider tap 0
        i_sel = 7'd64;
        wait_sel(7'd64, e_at);
        wait_valid(p_at);
        chk("t2_first_at", p_at - e_at, 16);
        chk("t2_first_cnt", count_a, 7);
        chk("t2_first_cnt2", count_b, 3);
        chk("t2_first_ovf2", ovf_b, 1);
        p_prev = p_at;
        wait_valid(p_at);
        chk("t2_period", p_at - p_prev, 16);
        chk("t2_cnt", count_a, 8);
        chk("t2_ovf", ovf_a, 0);
        chk("t2_cnt2", count_b, 3);
        chk("t2_ovf2", ovf_b, 1);
        p_prev = p_at;
        wait_valid(p_at);
        chk("t2_period2", p_at - p_prev, 16);
        chk("t2_cnt_b", count_a, 8);

        // 3: divider tap 3, one edge per window
        i_sel = 7'd67;
        wait_sel(7'd67, e_at);
        chk("t3_ovf2_held", ovf_b, 1);
        chk("t3_cnt_held", count_a, 8);
        wait_valid(p_at);
        wait_valid(p_at);
        chk("t3_cnt", count_a, 1);
        chk("t3_cnt2", count_b, 1);
        chk("t3_ovf2", ovf_b, 0);

        // 4: glitch rejection, then a real change with no spurious edge
        i_probe = 64'h400;
        i_sel   = 7'd5;
        wait_sel(7'd5, e_at);
        wait_valid(p_at);
        chk("t4_align", p_at - e_at, 16);
        p_prev = p_at;
        ticks(2);
        i_sel = 7'd6;
        tick();
        i_sel = 7'd5;
        ticks(6);
        chk("t4_glitch_sel", sel_a, 5);
        wait_valid(p_at);
        chk("t4_glitch_period", p_at - p_prev, 16);
        chk("t4_cnt5", count_a, 0);
        ticks(3);
        i_sel = 7'd10;
        wait_sel(7'd10, e_at);
        wait_valid(p_at);
        chk("t4_restart_at", p_at - e_at, 16);
        chk("t4_cnt10", count_a, 0);
        chk("t4_ovf10", ovf_a, 0);
        p_prev = p_at;

        // 5: select change landing on the window-end cycle
        ticks(12);
        i_sel = 7'd64;
        ticks(4);
        chk("t5_sel", sel_a, 64);
        chk("t5_no_valid", valid_a, 0);
        wait_valid(p_at);
        chk("t5_next_at", p_at - p_prev, 32);
        chk("t5_cnt", count_a, 7);
        chk("t5_cnt2", count_b, 3);
        chk("t5_ovf2", ovf_b, 1);
        wait_valid(p_at);
        chk("t5_cnt_full", count_a, 8);
        i_sel = 7'd127;
        wait_sel(7'd127, e_at);
        tick();
        chk("t5_unmapped_debug", debug_a, 0);
        wait_valid(p_at);
        chk("t5_unmapped_at", p_at - e_at, 16);
        chk("t5_unmapped_cnt", count_a, 0);
        chk("t5_unmapped_ovf2", ovf_b, 0);

        // 6: ena dropped for three cycles mid-window
        i_sel = 7'd64;
        wait_sel(7'd64, e_at);
        wait_valid(p_at);
        wait_valid(p_at);
        chk("t6_pre_cnt", count_a, 8);
        ticks(5);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_off_debug", debug_a, 0);
            chk("t6_off_sel", sel_a, 0);
            chk("t6_off_cnt", count_a, 0);
            chk("t6_off_valid", valid_a, 0);
            chk("t6_off_ovf2", ovf_b, 0);
        end
        ena = 1'b1;
        ticks(3);
        chk("t6_sel_lat3", sel_a, 0);
        tick();
        chk("t6_sel_lat4", sel_a, 64);
        e_at = cyc;
        wait_valid(p_at);
        chk("t6_first_at", p_at - e_at, 16);
        chk("t6_first_cnt", count_a, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
